writeback_cycle: RTL and testbench

Final pipeline stage of the 16-bit processor: accepts a retiring instruction's result selection from the memory stage, waits for load data when needed, and drives the register-file write port (`writelocation`, `writedata`, `regwrite`) consumed by `decode_cycle`. It owns the load-wait state machine, a bounded memory timeout, and the stall back-pressure to upstream stages.

---
 rtl/writeback_cycle_if.sv | 28 ++
 rtl/writeback_cycle.sv | 91 +++++++++
 tb/tb_writeback_cycle.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/writeback_cycle_if.sv
// Writeback-stage bundle: retiring instruction and load data in,
// register-file write port and status out.
interface writeback_cycle_if;
    logic        in_valid;
    logic [3:0]  rd_in;
    logic        regwrite_in;
    logic [1:0]  wbsel;
    logic [15:0] aluout;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [15:0] memdata;
    logic        memvalid;
    logic [3:0]  writelocation;
    logic [15:0] writedata;
    logic        regwrite;
    logic        stall;
    logic        mem_err;

    // master: memory stage / bench side; slave: the writeback stage itself
    modport master (
        output in_valid, rd_in, regwrite_in, wbsel, aluout, pc, imm, memdata, memvalid,
        input  writelocation, writedata, regwrite, stall, mem_err
    );
    modport slave (
        input  in_valid, rd_in, regwrite_in, wbsel, aluout, pc, imm, memdata, memvalid,
        output writelocation, writedata, regwrite, stall, mem_err
    );
endinterface

// File: rtl/writeback_cycle.sv
// Final pipeline stage: selects the retiring result, waits for late load
// data with a bounded timeout, and drives the register-file write port.
module writeback_cycle #(
    parameter int MEM_TIMEOUT        = 15,
    parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
    input logic              clk,
    input logic              rst,
    writeback_cycle_if.slave wb
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 1);

    logic [0:0]  state;
    logic [3:0]  rd_q;
    logic        we_q;
    logic [7:0]  cnt;
    logic [3:0]  writelocation;
    logic [15:0] writedata;
    logic        regwrite;
    logic        mem_err;

    logic        we;
    logic        late_load;
    logic [15:0] sel_data;

    always_comb begin
        we        = wb.regwrite_in & ~(ZERO_REG_HARDWIRED & (wb.rd_in == 4'd0));
        late_load = (wb.wbsel == 2'b01) & ~wb.memvalid;
        sel_data  = wb.aluout;
        case (wb.wbsel)
            2'b00:   sel_data = wb.aluout;
            2'b01:   sel_data = wb.memdata;
            2'b10:   sel_data = wb.pc + 16'd2;
            default: sel_data = wb.imm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_q          <= 4'd0;
            we_q          <= 1'b0;
            cnt           <= 8'd0;
            writelocation <= 4'd0;
            writedata     <= 16'd0;
            regwrite      <= 1'b0;
            mem_err       <= 1'b0;
        end else begin
            regwrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb.in_valid) begin
                        if (late_load) begin
                            rd_q  <= wb.rd_in;
                            we_q  <= we;
                            cnt   <= 8'd0;
                            state <= WAIT_MEM;
                        end else begin
                            regwrite      <= we;
                            writelocation <= wb.rd_in;
                            writedata     <= sel_data;
                        end
                    end
                end
                WAIT_MEM: begin
                    // data arriving on the timeout cycle still wins
                    if (wb.memvalid) begin
                        regwrite      <= we_q;
                        writelocation <= rd_q;
                        writedata     <= wb.memdata;
                        state         <= IDLE;
                    end else if (cnt == LAST_CNT) begin
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.writelocation = writelocation;
    assign wb.writedata     = writedata;
    assign wb.regwrite      = regwrite;
    assign wb.stall         = (state == WAIT_MEM);
    assign wb.mem_err       = mem_err;
endmodule

// File: tb/tb_writeback_cycle.sv
// Scoreboard bench: expected register writes are queued as instructions are
// driven and matched against every regwrite strobe.
module tb_writeback_cycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [19:0] sb_q[$];

    writeback_cycle_if wb ();
    writeback_cycle #(.MEM_TIMEOUT(4), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rd, input logic rwi,
                         input logic [1:0] sel, input logic [15:0] alu,
                         input logic [15:0] pcv, input logic [15:0] immv,
                         input logic [15:0] md, input logic mv);
        wb.in_valid    = v;
        wb.rd_in       = rd;
        wb.regwrite_in = rwi;
        wb.wbsel       = sel;
        wb.aluout      = alu;
        wb.pc          = pcv;
        wb.imm         = immv;
        wb.memdata     = md;
        wb.memvalid    = mv;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    // Every write strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && wb.regwrite) begin
            if (sb_q.size() == 0) chk("sb_extra_write", {12'h0, wb.writelocation, wb.writedata}, 32'h0);
            else chk("sb_write", {12'h0, wb.writelocation, wb.writedata}, {12'h0, sb_q.pop_front()});
        end
    end

    initial begin
        int n;
        logic [15:0] v;
        idle();
        rst = 1'b1;
        tick(); tick();
        chk("rst_loc", 32'(wb.writelocation), 32'h0);
        chk("rst_data", 32'(wb.writedata), 32'h0);
        chk("rst_rw", 32'(wb.regwrite), 32'h0);
        chk("rst_stall", 32'(wb.stall), 32'h0);
        chk("rst_err", 32'(wb.mem_err), 32'h0);
        rst = 1'b0;

        // ALU writeback, strobe lasts exactly one cycle
        drive(1'b1, 4'd3, 1'b1, 2'b00, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0);
        sb_q.push_back({4'd3, 16'h1234});
        tick();
        chk("alu_rw", 32'(wb.regwrite), 32'h1);
        idle();
        tick();
        chk("alu_rw_drop", 32'(wb.regwrite), 32'h0);

        // link wraps, then rd0 write suppressed but location/data still update
        drive(1'b1, 4'd5, 1'b1, 2'b10, 16'h0, 16'hFFFE, 16'h0, 16'h0, 1'b0);
        sb_q.push_back({4'd5, 16'h0000});
        tick();
        drive(1'b1, 4'd0, 1'b1, 2'b00, 16'h5555, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("zero_rw", 32'(wb.regwrite), 32'h0);
        idle();
        tick();
        chk("hold_loc", 32'(wb.writelocation), 32'h0);
        chk("hold_data", 32'(wb.writedata), 32'h5555);

        // immediate, regwrite_in=0, and same-cycle load
        drive(1'b1, 4'd9, 1'b1, 2'b11, 16'h0, 16'h0, 16'hA5A5, 16'h0, 1'b0);
        sb_q.push_back({4'd9, 16'hA5A5});
        tick();
        drive(1'b1, 4'd10, 1'b0, 2'b00, 16'h7777, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 4'd2, 1'b1, 2'b01, 16'h0, 16'h0, 16'h0, 16'h1111, 1'b1);
        sb_q.push_back({4'd2, 16'h1111});
        tick();
        chk("fast_load_stall", 32'(wb.stall), 32'h0);

        // back-to-back ALU instructions, one per cycle
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom);
            drive(1'b1, 4'(i + 1), 1'b1, 2'b00, v, 16'h0, 16'h0, 16'h0, 1'b0);
            sb_q.push_back({4'(i + 1), v});
            tick();
            chk("b2b_stall", 32'(wb.stall), 32'h0);
        end

        // delayed load: memvalid three cycles after acceptance
        drive(1'b1, 4'd7, 1'b1, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        sb_q.push_back({4'd7, 16'hBEEF});
        tick();
        chk("dl_stall1", 32'(wb.stall), 32'h1);
        drive(1'b1, 4'd11, 1'b1, 2'b00, 16'hDEAD, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("dl_stall2", 32'(wb.stall), 32'h1);
        tick();
        chk("dl_stall3", 32'(wb.stall), 32'h1);
        chk("dl_rw_wait", 32'(wb.regwrite), 32'h0);
        wb.memdata  = 16'hBEEF;
        wb.memvalid = 1'b1;
        tick();
        idle();
        chk("dl_stall_fall", 32'(wb.stall), 32'h0);
        chk("dl_loc", 32'(wb.writelocation), 32'h7);
        chk("dl_data", 32'(wb.writedata), 32'hBEEF);
        tick();

        // memvalid with nothing pending is ignored
        wb.memvalid = 1'b1;
        wb.memdata  = 16'h4242;
        tick();
        idle();
        chk("stray_mv_rw", 32'(wb.regwrite), 32'h0);

        // timeout: stall high exactly MEM_TIMEOUT cycles, no write
        drive(1'b1, 4'd8, 1'b1, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!wb.stall) break;
            n++;
            chk("to_err_early", 32'(wb.mem_err), 32'h0);
            tick();
        end
        chk("to_stall_cycles", 32'(n), 32'd4);
        chk("to_err", 32'(wb.mem_err), 32'h1);
        drive(1'b1, 4'd4, 1'b1, 2'b00, 16'h0F0F, 16'h0, 16'h0, 16'h0, 1'b0);
        sb_q.push_back({4'd4, 16'h0F0F});
        tick();
        idle();
        chk("to_after_rw", 32'(wb.regwrite), 32'h1);
        chk("to_err_sticky", 32'(wb.mem_err), 32'h1);
        tick();

        // reset mid-load drops the pending write
        drive(1'b1, 4'd6, 1'b1, 2'b01, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        chk("rml_stall", 32'(wb.stall), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb.memvalid = 1'b1;
        wb.memdata  = 16'h9999;
        tick();
        chk("rml_stall_after", 32'(wb.stall), 32'h0);
        chk("rml_err_cleared", 32'(wb.mem_err), 32'h0);
        idle();
        tick();
        chk("rml_rw", 32'(wb.regwrite), 32'h0);
        tick();

        chk("sb_pending", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
